// File: rtl/apb_pkg.sv
// Shared types, constants and address-check helper for the APB completer register file.
package apb_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StAccess
   } apb_state_e;

   localparam int unsigned PSEL_W     = 3;
   localparam int unsigned ALIGN_BITS = 2;

   // Addresses are widened to 64 bits so one helper serves any ADDR_W up to 64.
   function automatic logic apb_addr_err(input logic [63:0] addr,
                                         input logic        write,
                                         input int unsigned num_regs);
      logic [63:0] limit;
      logic [63:0] ro_addr;
      limit   = 64'(num_regs) << ALIGN_BITS;
      ro_addr = limit - (64'd1 << ALIGN_BITS);
      return (addr[ALIGN_BITS-1:0] != '0) || (addr >= limit) || (write && (addr == ro_addr));
   endfunction

endpackage

// File: rtl/apb_completer_regfile_if.sv
// APB bus between the bridge (master) and one completer (slave).
interface apb_completer_regfile_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();

   logic [apb_pkg::PSEL_W-1:0] pselx;
   logic                       penable;
   logic                       pwrite;
   logic [ADDR_W-1:0]          paddr;
   logic [DATA_W-1:0]          pwdata;
   logic [DATA_W-1:0]          prdata;
   logic                       pready;
   logic                       pslverr;

   modport master (
      output pselx, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  pselx, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_regbank.sv
// Register storage: NUM_REGS-1 read/write words plus a read-only completion counter on top.
module apb_regbank #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              inc_i,
   input  logic [IDX_W-1:0]  ridx_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);

   logic [DATA_W-1:0] regs_q [NUM_REGS-1];
   logic [DATA_W-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NUM_REGS) - 1; i++) begin
            regs_q[i] <= '0;
         end
         count_q <= '0;
      end else begin
         if (we_i && (idx_i < LastIdx)) begin
            regs_q[idx_i] <= wdata_i;
         end
         if (inc_i) begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      if (ridx_i == LastIdx) begin
         rdata_o = count_q;
      end else if (ridx_i < LastIdx) begin
         rdata_o = regs_q[ridx_i];
      end
   end

endmodule

// File: rtl/apb_completer_regfile.sv
// APB completer servicing a small register bank with configurable wait states and error response.
module apb_completer_regfile
   import apb_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned SEL_IDX     = 0
) (
   input  logic                   hclk_i,
   input  logic                   hreset_i,
   apb_completer_regfile_if.slave bus
);

   localparam int unsigned IDX_W    = $clog2(NUM_REGS);
   localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

   apb_state_e        state_q, state_d;
   logic [3:0]        wait_q, wait_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              write_q, write_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              pready_q, pready_d;
   logic              pslverr_q, pslverr_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;

   logic              psel;
   logic              setup_err;
   logic              we;
   logic              inc;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rdata;
   logic              unused_psel;

   assign psel        = bus.pselx[SEL_IDX];
   assign unused_psel = ^bus.pselx;
   assign setup_err   = apb_addr_err(64'(bus.paddr), bus.pwrite, NUM_REGS);

   // With zero wait states the response is built from the live setup address.
   assign rd_idx = (state_q == StIdle) ? bus.paddr[ALIGN_BITS +: IDX_W] : idx_q;

   apb_regbank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_bank (
      .clk_i   (hclk_i),
      .rst_i   (hreset_i),
      .we_i    (we),
      .idx_i   (idx_q),
      .wdata_i (wdata_q),
      .inc_i   (inc),
      .ridx_i  (rd_idx),
      .rdata_o (rdata)
   );

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      idx_d     = idx_q;
      write_d   = write_q;
      err_d     = err_q;
      wdata_d   = wdata_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      prdata_d  = prdata_q;
      we        = 1'b0;
      inc       = 1'b0;

      unique case (state_q)
         StIdle: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            if (psel && !bus.penable) begin
               idx_d   = bus.paddr[ALIGN_BITS +: IDX_W];
               write_d = bus.pwrite;
               err_d   = setup_err;
               wdata_d = bus.pwdata;
               wait_d  = WaitInit;
               state_d = StAccess;
               if (WaitInit == 4'd0) begin
                  pready_d  = 1'b1;
                  pslverr_d = setup_err;
                  prdata_d  = (!bus.pwrite && !setup_err) ? rdata : '0;
               end
            end
         end
         StAccess: begin
            if (!psel || !bus.penable) begin
               state_d   = StIdle;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               prdata_d  = '0;
            end else if (pready_q) begin
               we        = write_q && !err_q;
               inc       = !err_q;
               state_d   = StIdle;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               prdata_d  = '0;
            end else begin
               if (wait_q == 4'd1) begin
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
                  prdata_d  = (!write_q && !err_q) ? rdata : '0;
               end
               if (wait_q != 4'd0) begin
                  wait_d = wait_q - 4'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge hclk_i) begin
      if (hreset_i) begin
         state_q   <= StIdle;
         wait_q    <= '0;
         idx_q     <= '0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         wdata_q   <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         idx_q     <= idx_d;
         write_q   <= write_d;
         err_q     <= err_d;
         wdata_q   <= wdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign bus.prdata  = prdata_q;
   assign bus.pready  = pready_q;
   assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Bench: three completers on one shared APB bus (one select bit each), checked against a model.
module tb_apb_completer_regfile;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        hclk = 1'b0;
   logic [2:0]  rst;
   logic [2:0]  pselx;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;

   logic [2:0]  rdy;
   logic [2:0]  slverr;
   logic [31:0] rd [3];

   int          errors = 0;
   int          checks = 0;
   exp_t        sb [$];
   logic [31:0] mdl  [3][7];
   logic [31:0] mcnt [3];
   logic [31:0] msk  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
   int          wait_of [3] = '{1, 0, 0};

   always #5 hclk = ~hclk;

   apb_completer_regfile_if #(.ADDR_W(32), .DATA_W(32)) if_a ();
   apb_completer_regfile_if #(.ADDR_W(32), .DATA_W(32)) if_b ();
   apb_completer_regfile_if #(.ADDR_W(32), .DATA_W(8))  if_c ();

   assign if_a.pselx = pselx;  assign if_b.pselx = pselx;  assign if_c.pselx = pselx;
   assign if_a.penable = penable;  assign if_b.penable = penable;  assign if_c.penable = penable;
   assign if_a.pwrite = pwrite;  assign if_b.pwrite = pwrite;  assign if_c.pwrite = pwrite;
   assign if_a.paddr = paddr;  assign if_b.paddr = paddr;  assign if_c.paddr = paddr;
   assign if_a.pwdata = pwdata;  assign if_b.pwdata = pwdata;  assign if_c.pwdata = pwdata[7:0];

   assign rdy    = {if_c.pready, if_b.pready, if_a.pready};
   assign slverr = {if_c.pslverr, if_b.pslverr, if_a.pslverr};
   assign rd[0]  = if_a.prdata;
   assign rd[1]  = if_b.prdata;
   assign rd[2]  = {24'h0, if_c.prdata};

   apb_completer_regfile #(
      .DATA_W(32), .ADDR_W(32), .NUM_REGS(8), .WAIT_CYCLES(1), .SEL_IDX(0)
   ) u_dut_a (
      .hclk_i(hclk), .hreset_i(rst[0]), .bus(if_a)
   );

   apb_completer_regfile #(
      .DATA_W(32), .ADDR_W(32), .NUM_REGS(8), .WAIT_CYCLES(0), .SEL_IDX(1)
   ) u_dut_b (
      .hclk_i(hclk), .hreset_i(rst[1]), .bus(if_b)
   );

   apb_completer_regfile #(
      .DATA_W(8), .ADDR_W(32), .NUM_REGS(8), .WAIT_CYCLES(0), .SEL_IDX(2)
   ) u_dut_c (
      .hclk_i(hclk), .hreset_i(rst[2]), .bus(if_c)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset(input int t);
      for (int i = 0; i < 7; i++) mdl[t][i] = 32'h0;
      mcnt[t] = 32'h0;
   endtask

   // Full transfer on target t; called at a negedge, returns one negedge after completion.
   task automatic xfer(input int t, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input string tag);
      exp_t        e;
      logic        err;
      int          idx;
      int          lat;
      bit          done;
      logic [2:0]  oth;
      err     = (addr[1:0] != 2'b00) || (addr >= 32'h20) || (wr && addr == 32'h1C);
      idx     = int'(addr[4:2]);
      e.err   = err;
      e.rdata = 32'h0;
      if (!wr && !err) e.rdata = (idx == 7) ? mcnt[t] : mdl[t][idx];
      if (!err) begin
         if (wr) mdl[t][idx] = data & msk[t];
         mcnt[t] = (mcnt[t] + 32'h1) & msk[t];
      end
      sb.push_back(e);

      pselx   = 3'(1 << t);
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      @(negedge hclk);
      penable = 1'b1;
      lat  = 0;
      done = 1'b0;
      while (!done && lat < 20) begin
         if (rdy[t]) done = 1'b1;
         else begin
            @(negedge hclk);
            lat++;
         end
      end
      chk({tag, " latency"}, 32'(lat), 32'(wait_of[t]));
      e = sb.pop_front();
      if (done) begin
         chk({tag, " prdata"}, rd[t], e.rdata);
         chk({tag, " pslverr"}, {31'h0, slverr[t]}, {31'h0, e.err});
         oth = rdy & ~(3'b001 << t);
         chk({tag, " others quiet"}, {29'h0, oth}, 32'h0);
      end
      @(negedge hclk);
      chk({tag, " pready drop"}, {31'h0, rdy[t]}, 32'h0);
   endtask

   task automatic idle();
      pselx   = 3'b000;
      penable = 1'b0;
      @(negedge hclk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 3'b111;
      pselx   = 3'b000;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 32'h0;
      pwdata  = 32'h0;
      for (int t = 0; t < 3; t++) model_reset(t);
      repeat (3) @(negedge hclk);
      rst = 3'b000;
      @(negedge hclk);
      chk("reset pready", {29'h0, rdy}, 32'h0);
      chk("reset pslverr", {29'h0, slverr}, 32'h0);
      chk("reset prdata", rd[0], 32'h0);

      // One wait state: write, readback, counter.
      xfer(0, 1'b1, 32'h04, 32'hDEAD_BEEF, "a wr04");
      xfer(0, 1'b0, 32'h04, 32'h0, "a rd04");
      xfer(0, 1'b0, 32'h1C, 32'h0, "a cnt");
      idle();

      // Zero wait states, back-to-back with no idle cycle.
      xfer(1, 1'b1, 32'h00, 32'h1111_1111, "b wr00");
      xfer(1, 1'b1, 32'h08, 32'h2222_2222, "b wr08");
      xfer(1, 1'b1, 32'h0C, 32'h3333_3333, "b wr0c");
      xfer(1, 1'b0, 32'h00, 32'h0, "b rd00");
      xfer(1, 1'b0, 32'h08, 32'h0, "b rd08");
      xfer(1, 1'b0, 32'h0C, 32'h0, "b rd0c");
      idle();

      // Error responses; the counter must not move.
      xfer(0, 1'b0, 32'h02, 32'h0, "a misaligned");
      xfer(0, 1'b0, 32'h20, 32'h0, "a out of range");
      xfer(0, 1'b1, 32'h1C, 32'h1234_5678, "a write ro");
      xfer(0, 1'b0, 32'h8000_0004, 32'h0, "a upper bits");
      xfer(0, 1'b0, 32'h1C, 32'h0, "a cnt after err");
      idle();

      // pselx=010 addresses only target 1; target 0 must stay silent and unchanged.
      xfer(1, 1'b1, 32'h10, 32'hCAFE_F00D, "b wr10");
      xfer(0, 1'b0, 32'h10, 32'h0, "a rd10 untouched");
      idle();

      // psel dropped during the wait state.
      pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hA5A5_A5A5;
      @(negedge hclk);
      penable = 1'b1;
      chk("abort wait pready", {31'h0, rdy[0]}, 32'h0);
      pselx = 3'b000;
      @(negedge hclk);
      penable = 1'b0;
      chk("abort pready", {31'h0, rdy[0]}, 32'h0);
      chk("abort prdata", rd[0], 32'h0);
      chk("abort pslverr", {31'h0, slverr[0]}, 32'h0);
      xfer(0, 1'b0, 32'h08, 32'h0, "a rd08 after abort");
      xfer(0, 1'b0, 32'h1C, 32'h0, "a cnt after abort");
      idle();

      // Reset in the middle of ACCESS.
      pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h5555_AAAA;
      @(negedge hclk);
      penable = 1'b1;
      rst[0]  = 1'b1;
      @(negedge hclk);
      rst[0]  = 1'b0;
      pselx   = 3'b000;
      penable = 1'b0;
      model_reset(0);
      chk("midreset pready", {31'h0, rdy[0]}, 32'h0);
      chk("midreset prdata", rd[0], 32'h0);
      chk("midreset pslverr", {31'h0, slverr[0]}, 32'h0);
      @(negedge hclk);
      xfer(0, 1'b0, 32'h04, 32'h0, "a rd04 after reset");
      xfer(0, 1'b1, 32'h04, 32'h1234_5678, "a wr04 after reset");
      xfer(0, 1'b0, 32'h04, 32'h0, "a rd04 again");
      xfer(0, 1'b0, 32'h1C, 32'h0, "a cnt after reset");
      idle();

      // 8-bit completer: drive the counter to its top value and across the wrap.
      for (int i = 0; i < 300 && mcnt[2] != 32'hFF; i++) begin
         xfer(2, 1'b1, 32'h00, 32'(i), "c fill");
      end
      xfer(2, 1'b0, 32'h1C, 32'h0, "c cnt top");
      xfer(2, 1'b0, 32'h1C, 32'h0, "c cnt wrapped");
      xfer(2, 1'b0, 32'h00, 32'h0, "c rd00");
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
